// File: rtl/eeg_epoch_loader.sv
`default_nettype none
// ============================================================================
//  Module      : eeg_epoch_loader
//  Description : Accepts raw EEG samples over valid/ready, converts each one
//                to the compute fixed-point format and writes it to
//                consecutive intermediate-result addresses. After a full
//                epoch it pulses new_sleep_epoch, then waits for
//                inference_complete before loading the next epoch.
//                Optional build macro EEG_LOADER_DROP_EN: while waiting for
//                inference, keep accepting samples and discard them, counting
//                each one in dropped_count (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module eeg_epoch_loader #(
    parameter int NUM_SAMPLES = 3840,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 16,
    parameter int SAMPLE_W    = 16,
    parameter int DATA_W      = 22,
    parameter int FRAC_SHIFT  = 4,
    parameter int FORMAT_CODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                int_res_write_en,
    output logic                int_res_chip_en,
    output logic [ADDR_W-1:0]   int_res_write_addr,
    output logic [DATA_W-1:0]   int_res_write_data,
    output logic                int_res_write_data_width,
    output logic [2:0]          int_res_write_format,
    output logic                new_sleep_epoch,
    input  logic                inference_complete,
    output logic [15:0]         epoch_count,
    output logic [15:0]         dropped_count
);

    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

`ifdef EEG_LOADER_DROP_EN
    // Keep the upstream ADC flowing while the accelerator is busy.
    localparam logic WAIT_READY = 1'b1;
`else
    // Back-pressure the upstream source while the accelerator is busy.
    localparam logic WAIT_READY = 1'b0;
`endif

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        TRIGGER  = 2'd1,
        WAIT_INF = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic                 ready_nxt;
    logic                 write_nxt;
    logic                 pulse_nxt;
    logic                 handshake;
    logic                 last_sample;
    logic signed [SAMPLE_W-1:0] sample_s;
    logic signed [DATA_W-1:0]   sample_ext;
    logic [DATA_W-1:0]          sample_conv;

    assign handshake   = sample_valid & sample_ready;
    assign last_sample = (idx == IDX_W'(NUM_SAMPLES - 1));

    // Sign-extend to the compute width, then scale into the fractional format.
    assign sample_s    = sample_data;
    assign sample_ext  = DATA_W'(sample_s);
    assign sample_conv = sample_ext << FRAC_SHIFT;

    assign int_res_write_data_width = 1'b0;
    assign int_res_write_format     = 3'(FORMAT_CODE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output decode; all outputs are registered below.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ready_nxt = sample_ready;
        write_nxt = 1'b0;
        pulse_nxt = 1'b0;
        case (state)
            FILL: begin
                ready_nxt = 1'b1;
                if (handshake) begin
                    write_nxt = 1'b1;
                    if (last_sample) begin
                        // Drop ready together with the final write so no
                        // sample of the next epoch slips in before TRIGGER.
                        idx_nxt   = '0;
                        ready_nxt = 1'b0;
                        state_nxt = TRIGGER;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            TRIGGER: begin
                pulse_nxt = 1'b1;
                ready_nxt = WAIT_READY;
                state_nxt = WAIT_INF;
            end
            WAIT_INF: begin
                ready_nxt = WAIT_READY;
                if (inference_complete) begin
                    ready_nxt = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: begin
                idx_nxt   = '0;
                ready_nxt = 1'b0;
                state_nxt = FILL;
            end
        endcase
    end

    // Sample index, handshake output and memory write port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx                <= '0;
            sample_ready       <= 1'b0;
            int_res_write_en   <= 1'b0;
            int_res_chip_en    <= 1'b0;
            int_res_write_addr <= ADDR_W'(BASE_ADDR);
            int_res_write_data <= '0;
        end else begin
            idx              <= idx_nxt;
            sample_ready     <= ready_nxt;
            int_res_write_en <= write_nxt;
            int_res_chip_en  <= write_nxt;
            if (write_nxt) begin
                int_res_write_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx);
                int_res_write_data <= sample_conv;
            end
        end
    end

    // Epoch hand-off pulse and completed-epoch counter (wraps naturally).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_sleep_epoch <= 1'b0;
            epoch_count     <= 16'd0;
        end else begin
            new_sleep_epoch <= pulse_nxt;
            if (pulse_nxt) begin
                epoch_count <= epoch_count + 16'd1;
            end
        end
    end

`ifdef EEG_LOADER_DROP_EN
    // Count samples discarded while waiting for inference, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_count <= 16'd0;
        end else if ((state == WAIT_INF) && handshake && (dropped_count != 16'hFFFF)) begin
            dropped_count <= dropped_count + 16'd1;
        end
    end
`else
    assign dropped_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eeg_epoch_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eeg_epoch_loader
//  Description : Self-checking bench for eeg_epoch_loader with a small
//                per-cycle behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eeg_epoch_loader;

    localparam int N        = 4;
    localparam int BASE     = 16;
    localparam int ADDR_W   = 16;
    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 22;
    localparam int FRAC     = 4;
    localparam int FMT      = 0;
`ifdef EEG_LOADER_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    localparam int P_FILL = 0;
    localparam int P_TRIG = 1;
    localparam int P_WAIT = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                sample_valid;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample_data;
    logic                int_res_write_en;
    logic                int_res_chip_en;
    logic [ADDR_W-1:0]   int_res_write_addr;
    logic [DATA_W-1:0]   int_res_write_data;
    logic                int_res_write_data_width;
    logic [2:0]          int_res_write_format;
    logic                new_sleep_epoch;
    logic                inference_complete;
    logic [15:0]         epoch_count;
    logic [15:0]         dropped_count;

    eeg_epoch_loader #(
        .NUM_SAMPLES (N),
        .BASE_ADDR   (BASE),
        .ADDR_W      (ADDR_W),
        .SAMPLE_W    (SAMPLE_W),
        .DATA_W      (DATA_W),
        .FRAC_SHIFT  (FRAC),
        .FORMAT_CODE (FMT)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .sample_valid             (sample_valid),
        .sample_ready             (sample_ready),
        .sample_data              (sample_data),
        .int_res_write_en         (int_res_write_en),
        .int_res_chip_en          (int_res_chip_en),
        .int_res_write_addr       (int_res_write_addr),
        .int_res_write_data       (int_res_write_data),
        .int_res_write_data_width (int_res_write_data_width),
        .int_res_write_format     (int_res_write_format),
        .new_sleep_epoch          (new_sleep_epoch),
        .inference_complete       (inference_complete),
        .epoch_count              (epoch_count),
        .dropped_count            (dropped_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int   m_phase;
    int   m_n;
    bit   m_ready;
    bit   m_we;
    bit   m_pulse;
    int   m_addr;
    int   m_data;
    int   m_epoch;
    int   m_dropped;
    int   m_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_FILL;
        m_n       = 0;
        m_ready   = 1'b0;
        m_we      = 1'b0;
        m_pulse   = 1'b0;
        m_addr    = BASE;
        m_data    = 0;
        m_epoch   = 0;
        m_dropped = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ready"},   32'(sample_ready),             32'(m_ready));
        check({tag, ".we"},      32'(int_res_write_en),         32'(m_we));
        check({tag, ".ce"},      32'(int_res_chip_en),          32'(m_we));
        check({tag, ".addr"},    32'(int_res_write_addr),       32'(m_addr));
        check({tag, ".data"},    32'(int_res_write_data),       32'(m_data));
        check({tag, ".pulse"},   32'(new_sleep_epoch),          32'(m_pulse));
        check({tag, ".epoch"},   32'(epoch_count),              32'(m_epoch));
        check({tag, ".dropped"}, 32'(dropped_count),            32'(m_dropped));
        check({tag, ".width"},   32'(int_res_write_data_width), 32'(0));
        check({tag, ".format"},  32'(int_res_write_format),     32'(FMT));
    endtask

    // One clock: drive inputs, advance the model, compare every output.
    task automatic cycle(input string tag, input logic v, input logic [15:0] d, input logic inf);
        bit hs;
        int ph;
        longint conv;
        sample_valid       = v;
        sample_data        = d;
        inference_complete = inf;
        hs = v && m_ready;
        ph = m_phase;
        @(posedge clk);
        #1;
        m_we    = 1'b0;
        m_pulse = 1'b0;
        if (ph == P_FILL) begin
            m_ready = 1'b1;
            if (hs) begin
                conv   = longint'($signed(d)) * (64'sd1 << FRAC);
                m_we   = 1'b1;
                m_addr = BASE + m_n;
                m_data = int'(conv & ((64'sd1 << DATA_W) - 1));
                m_n++;
                if (m_n == N) begin
                    m_n     = 0;
                    m_phase = P_TRIG;
                    m_ready = 1'b0;
                end
            end
        end else if (ph == P_TRIG) begin
            m_pulse = 1'b1;
            m_pulses++;
            m_epoch = (m_epoch + 1) % 65536;
            m_phase = P_WAIT;
            m_ready = DROP;
        end else begin
            if (hs && m_dropped < 65535) m_dropped++;
            if (inf) begin
                m_phase = P_FILL;
                m_ready = 1'b1;
            end
        end
        check_all(tag);
    endtask

    initial begin
        int guard;
        int pulses_before;
        rst                = 1'b1;
        sample_valid       = 1'b0;
        sample_data        = '0;
        inference_complete = 1'b0;
        m_pulses           = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Directed epoch: 1, -1, 0x7FFF, 0 back-to-back
        cycle("d_idle", 1'b0, 16'h0000, 1'b0);
        cycle("d_s0",   1'b1, 16'h0001, 1'b0);
        check("d_s0.data_const", 32'(int_res_write_data), 32'h10);
        cycle("d_s1",   1'b1, 16'hFFFF, 1'b0);
        check("d_s1.data_const", 32'(int_res_write_data), 32'h3FFFF0);
        cycle("d_s2",   1'b1, 16'h7FFF, 1'b0);
        check("d_s2.data_const", 32'(int_res_write_data), 32'h7FFF0);
        cycle("d_s3",   1'b1, 16'h0000, 1'b0);
        check("d_s3.addr_const", 32'(int_res_write_addr), 32'h13);
        check("d_s3.no_pulse_yet", 32'(new_sleep_epoch), 32'(0));
        cycle("d_trig", 1'b0, 16'h0000, 1'b0);
        check("d_trig.pulse_const", 32'(new_sleep_epoch), 32'(1));
        check("d_trig.epoch_const", 32'(epoch_count), 32'(1));

        // Valid held high while waiting for inference
        repeat (10) cycle("stall", 1'b1, 16'($urandom), 1'b0);
        check("stall.dropped_const", 32'(dropped_count), DROP ? 32'd10 : 32'd0);
        cycle("release", 1'b0, 16'h0000, 1'b1);

        // Random valid, occasional inference_complete
        repeat (80) cycle("rand", 1'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));

        // inference_complete held high throughout
        pulses_before = m_pulses;
        repeat (60) cycle("infhi", 1'($urandom), 16'($urandom), 1'b1);
        check("infhi.some_pulse", 32'(m_pulses > pulses_before), 32'(1));

        // Reset after two samples of a fresh epoch
        guard = 0;
        while (!(m_phase == P_FILL && m_n == 0 && m_ready) && guard < 50) begin
            cycle("align", 1'b1, 16'($urandom), 1'b1);
            guard++;
        end
        check("align.reached", 32'(guard < 50), 32'(1));
        cycle("pre_rst0", 1'b1, 16'h1234, 1'b0);
        cycle("pre_rst1", 1'b1, 16'h8001, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("midrst");
        @(posedge clk);
        #1;
        check_all("midrst_hold");
        rst = 1'b0;
        cycle("post_idle", 1'b0, 16'h0000, 1'b0);
        cycle("post_s0",   1'b1, 16'h0ABC, 1'b0);
        check("post_s0.addr_const", 32'(int_res_write_addr), 32'h10);
        check("post_s0.epoch_const", 32'(epoch_count), 32'(0));
        for (int i = 1; i < N; i++) cycle("post_s", 1'b1, 16'($urandom), 1'b0);
        cycle("post_trig", 1'b0, 16'h0000, 1'b0);
        check("post_trig.epoch_const", 32'(epoch_count), 32'(1));
        cycle("post_wait", 1'b0, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
